// File: rtl/fb_rect_writer.sv
// Rectangle-fill write engine for the 640x480 RGB444 frame buffer.
// Clips the command to the frame once, then streams one pixel write per accepted cycle.
module fb_rect_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_x0,
    input  logic [9:0]  cmd_y0,
    input  logic [9:0]  cmd_w,
    input  logic [9:0]  cmd_h,
    input  logic [11:0] cmd_color,
    output logic        mem_en,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        done
);

    // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
    // a pixel write commits on a rising edge where mem_en && mem_ready, and the
    // presented address/data hold unchanged until that happens.

    typedef enum logic [1:0] {IDLE, CLIP, WRITE, DONE} state_t;

    localparam logic [10:0] H_RES_W = 11'(H_RES);
    localparam logic [10:0] V_RES_W = 11'(V_RES);
    localparam logic [18:0] ROW_STEP = 19'(H_RES);

    state_t      state_q, state_d;
    logic [9:0]  x0_q, x0_d;
    logic [9:0]  y0_q, y0_d;
    logic [9:0]  w_q, w_d;
    logic [9:0]  h_q, h_d;
    logic [11:0] color_q, color_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] x_end_q, x_end_d;
    logic [10:0] y_end_q, y_end_d;
    logic [18:0] row_base_q, row_base_d;

    logic [10:0] x_sum;
    logic [10:0] y_sum;
    logic        empty;
    logic        x_last;
    logic        y_last;
    logic        commit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            x0_q       <= '0;
            y0_q       <= '0;
            w_q        <= '0;
            h_q        <= '0;
            color_q    <= '0;
            x_q        <= '0;
            y_q        <= '0;
            x_end_q    <= '0;
            y_end_q    <= '0;
            row_base_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y0_q       <= y0_d;
            w_q        <= w_d;
            h_q        <= h_d;
            color_q    <= color_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_end_q    <= x_end_d;
            y_end_q    <= y_end_d;
            row_base_q <= row_base_d;
        end
    end

    // 11-bit sums so x0+w cannot wrap before the clip compare.
    assign x_sum  = {1'b0, x0_q} + {1'b0, w_q};
    assign y_sum  = {1'b0, y0_q} + {1'b0, h_q};
    assign empty  = (w_q == 10'd0) || (h_q == 10'd0) ||
                    ({1'b0, x0_q} >= H_RES_W) || ({1'b0, y0_q} >= V_RES_W);
    assign x_last = ({1'b0, x_q} == (x_end_q - 11'd1));
    assign y_last = ({1'b0, y_q} == (y_end_q - 11'd1));
    assign commit = (state_q == WRITE) && mem_ready;

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y0_d       = y0_q;
        w_d        = w_q;
        h_d        = h_q;
        color_d    = color_q;
        x_d        = x_q;
        y_d        = y_q;
        x_end_d    = x_end_q;
        y_end_d    = y_end_q;
        row_base_d = row_base_q;
        cmd_ready  = 1'b0;
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    x0_d    = cmd_x0;
                    y0_d    = cmd_y0;
                    w_d     = cmd_w;
                    h_d     = cmd_h;
                    color_d = cmd_color;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                x_end_d = (x_sum > H_RES_W) ? H_RES_W : x_sum;
                y_end_d = (y_sum > V_RES_W) ? V_RES_W : y_sum;
                if (empty) begin
                    state_d = DONE;
                end else begin
                    x_d        = x0_q;
                    y_d        = y0_q;
                    row_base_d = 19'(y0_q) * ROW_STEP;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_addr  = row_base_q + 19'(x_q);
                mem_wdata = {4'h0, color_q};
                if (commit) begin
                    if (!x_last) begin
                        x_d = x_q + 10'd1;
                    end else if (!y_last) begin
                        x_d        = x0_q;
                        y_d        = y_q + 10'd1;
                        row_base_d = row_base_q + ROW_STEP;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = mem_en;

endmodule
